// File: rtl/sync_fifo_param_if.sv
// -----------------------------------------------------------------------------
// sync_fifo_param_if
//   Signal bundle between a producer/consumer pair and sync_fifo_param.
//   Clock and reset are kept as plain ports on the FIFO itself.
//
//   master modport : drives wr_en, data_in, rd_en; observes data and status
//   slave  modport : the FIFO side (reverse directions)
//
//   Signals:
//     wr_en, data_in         write request and data
//     rd_en                  read request
//     data_out               registered read data
//     full, empty            count == DEPTH / count == 0
//     almost_full/_empty     count >= AF_THRESH / count <= AE_THRESH
//     count                  occupancy 0..DEPTH
//     overflow, underflow    sticky rejected-request flags (optional feature)
// -----------------------------------------------------------------------------
interface sync_fifo_param_if #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic              wr_en;
  logic [DATA_W-1:0] data_in;
  logic              rd_en;
  logic [DATA_W-1:0] data_out;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [CNT_W-1:0]  count;
  logic              overflow;
  logic              underflow;

  modport master (
    output wr_en, data_in, rd_en,
    input  data_out, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );

  modport slave (
    input  wr_en, data_in, rd_en,
    output data_out, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );
endinterface

// File: rtl/sync_fifo_param.sv
// -----------------------------------------------------------------------------
// sync_fifo_param
//   Parametrised single-clock FIFO with occupancy count, almost-full /
//   almost-empty thresholds and optional sticky overflow/underflow flags.
//
//   Ports:
//     clk   sole clock, all logic on posedge
//     rst   synchronous reset, active-low
//     fifo  sync_fifo_param_if.slave bundle (requests, data, status)
//
//   Optional feature macro: FIFO_ERR_FLAGS_EN
//     defined   : overflow/underflow set on rejected writes/reads and stay set
//                 until reset; rejected requests also raise a simulation
//                 assertion error.
//     undefined : overflow/underflow tied low, no assertion compiled.
//
//   Status flags are decodes of the count register only, so no input reaches
//   an output combinationally. Storage is not reset.
// -----------------------------------------------------------------------------
module sync_fifo_param #(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input logic               clk,
  input logic               rst,
  sync_fifo_param_if.slave  fifo
);
  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(AF_THRESH);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(AE_THRESH);

  logic [DATA_W-1:0] mem_q [DEPTH];

  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] data_out_q, data_out_d;

  logic full_w, empty_w;
  logic rd_acc, wr_acc;

  assign full_w  = (count_q == DEPTH_C);
  assign empty_w = (count_q == '0);

  // A write into a full FIFO is still taken when a read frees a slot in the
  // same cycle; a read of an empty FIFO never bypasses the incoming write.
  assign rd_acc = fifo.rd_en & ~empty_w;
  assign wr_acc = fifo.wr_en & (~full_w | rd_acc);

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    data_out_d = data_out_q;

    if (wr_acc) wr_ptr_d = wr_ptr_q + AW'(1);
    if (rd_acc) begin
      rd_ptr_d   = rd_ptr_q + AW'(1);
      data_out_d = mem_q[rd_ptr_q];
    end

    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      data_out_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && wr_acc) mem_q[wr_ptr_q] <= fifo.data_in;
  end

  assign fifo.data_out     = data_out_q;
  assign fifo.count        = count_q;
  assign fifo.full         = full_w;
  assign fifo.empty        = empty_w;
  assign fifo.almost_full  = (count_q >= AF_C);
  assign fifo.almost_empty = (count_q <= AE_C);

`ifdef FIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underflow_q, underflow_d;

  assign overflow_d  = overflow_q  | (fifo.wr_en & ~wr_acc);
  assign underflow_d = underflow_q | (fifo.rd_en & ~rd_acc);

  always_ff @(posedge clk) begin
    if (!rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign fifo.overflow  = overflow_q;
  assign fifo.underflow = underflow_q;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst) begin
      assert (!(fifo.wr_en && !wr_acc))
        else $error("sync_fifo_param: write rejected at count %0d", count_q);
      assert (!(fifo.rd_en && !rd_acc))
        else $error("sync_fifo_param: read rejected at count %0d", count_q);
    end
  end
`endif
`else
  assign fifo.overflow  = 1'b0;
  assign fifo.underflow = 1'b0;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
module tb_sync_fifo_param;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int AF_T   = 14;
  localparam int AE_T   = 2;

`ifdef FIFO_ERR_FLAGS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  sync_fifo_param_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  sync_fifo_param #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .AF_THRESH(AF_T), .AE_THRESH(AE_T)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .fifo (bus)
  );

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  // Reference model: a queue of stored words plus the last read word.
  logic [DATA_W-1:0] mq[$];
  logic [DATA_W-1:0] m_dout = '0;
  bit                m_ovf  = 1'b0;
  bit                m_unf  = 1'b0;

  always @(posedge clk) begin
    bit rd_ok, wr_ok;
    if (!rst) begin
      mq.delete();
      m_dout = '0;
      m_ovf  = 1'b0;
      m_unf  = 1'b0;
    end else begin
      rd_ok = bus.rd_en && (mq.size() > 0);
      wr_ok = bus.wr_en && ((mq.size() < DEPTH) || rd_ok);
      if (ERR_EN && bus.wr_en && !wr_ok) m_ovf = 1'b1;
      if (ERR_EN && bus.rd_en && !rd_ok) m_unf = 1'b1;
      if (rd_ok) m_dout = mq.pop_front();
      if (wr_ok) mq.push_back(bus.data_in);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("count",        32'(bus.count),        32'(mq.size()));
      chk("empty",        32'(bus.empty),        32'(mq.size() == 0));
      chk("full",         32'(bus.full),         32'(mq.size() == DEPTH));
      chk("almost_full",  32'(bus.almost_full),  32'(mq.size() >= AF_T));
      chk("almost_empty", 32'(bus.almost_empty), 32'(mq.size() <= AE_T));
      chk("data_out",     32'(bus.data_out),     32'(m_dout));
      chk("overflow",     32'(bus.overflow),     32'(m_ovf));
      chk("underflow",    32'(bus.underflow),    32'(m_unf));
    end
  end

  // Drive one cycle of requests, then return 1 ns after the edge.
  task automatic cyc(input bit wr, input logic [7:0] d, input bit rd);
    bus.wr_en   = wr;
    bus.data_in = d;
    bus.rd_en   = rd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.wr_en   = 1'b0;
    bus.data_in = '0;
    bus.rd_en   = 1'b0;
    rst         = 1'b0;

    // Reset for two cycles
    cyc(1'b0, 8'h00, 1'b0);
    chk_en = 1'b1;
    cyc(1'b0, 8'h00, 1'b0);
    chk("rst count",   32'(bus.count),        32'd0);
    chk("rst empty",   32'(bus.empty),        32'd1);
    chk("rst ae",      32'(bus.almost_empty), 32'd1);
    chk("rst full",    32'(bus.full),         32'd0);
    chk("rst af",      32'(bus.almost_full),  32'd0);
    chk("rst dout",    32'(bus.data_out),     32'h00);
    rst = 1'b1;

    // Fill with 0x00..0x0F
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 8'(i), 1'b0);
      if (i == 12) chk("af at 13", 32'(bus.almost_full), 32'd0);
      if (i == 13) chk("af at 14", 32'(bus.almost_full), 32'd1);
      if (i == 14) chk("full at 15", 32'(bus.full), 32'd0);
    end
    chk("fill count", 32'(bus.count), 32'd16);
    chk("fill full",  32'(bus.full),  32'd1);
    cyc(1'b1, 8'hAA, 1'b0);
    chk("ovf count",  32'(bus.count),    32'd16);
    chk("ovf flag",   32'(bus.overflow), 32'(ERR_EN));

    // Drain 16 words
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      chk("drain dout", 32'(bus.data_out), 32'(i));
    end
    chk("drain empty", 32'(bus.empty), 32'd1);
    cyc(1'b0, 8'h00, 1'b1);
    chk("unf dout", 32'(bus.data_out),  32'h0F);
    chk("unf flag", 32'(bus.underflow), 32'(ERR_EN));

    // Wrap: two batches of 10 cross the pointer wrap
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < 10; i++) cyc(1'b1, 8'(8'h20 + 8'(b * 16) + 8'(i)), 1'b0);
      chk("wrap count", 32'(bus.count), 32'd10);
      for (int i = 0; i < 10; i++) begin
        cyc(1'b0, 8'h00, 1'b1);
        chk("wrap dout", 32'(bus.data_out), 32'(8'h20 + 8'(b * 16) + 8'(i)));
      end
    end
    chk("wrap end count", 32'(bus.count), 32'd0);

    // Simultaneous read/write at full
    for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h60 + 8'(i)), 1'b0);
    cyc(1'b1, 8'h99, 1'b1);
    chk("rw full count", 32'(bus.count),    32'd16);
    chk("rw full dout",  32'(bus.data_out), 32'h60);
    for (int i = 1; i < 16; i++) begin
      cyc(1'b0, 8'h00, 1'b1);
      chk("rw drain", 32'(bus.data_out), 32'(8'h60 + 8'(i)));
    end
    cyc(1'b0, 8'h00, 1'b1);
    chk("rw new word", 32'(bus.data_out), 32'h99);
    chk("rw empty",    32'(bus.empty),    32'd1);

    // Simultaneous read/write at empty: write only
    cyc(1'b1, 8'h77, 1'b1);
    chk("rw empty count", 32'(bus.count),    32'd1);
    chk("rw empty dout",  32'(bus.data_out), 32'h99);
    cyc(1'b0, 8'h00, 1'b1);
    chk("rw empty read",  32'(bus.data_out), 32'h77);

    // Reset mid-operation at count 7 with a write pending
    for (int i = 0; i < 7; i++) cyc(1'b1, 8'(8'h10 + 8'(i)), 1'b0);
    chk("pre-rst count", 32'(bus.count), 32'd7);
    rst = 1'b0;
    cyc(1'b1, 8'h33, 1'b0);
    chk("mid rst count", 32'(bus.count),     32'd0);
    chk("mid rst empty", 32'(bus.empty),     32'd1);
    chk("mid rst dout",  32'(bus.data_out),  32'h00);
    chk("mid rst ovf",   32'(bus.overflow),  32'd0);
    chk("mid rst unf",   32'(bus.underflow), 32'd0);
    rst = 1'b1;
    cyc(1'b1, 8'h5C, 1'b0);
    cyc(1'b0, 8'h00, 1'b1);
    chk("post rst read", 32'(bus.data_out), 32'h5C);
    chk("post rst cnt",  32'(bus.count),    32'd0);

    cyc(1'b0, 8'h00, 1'b0);
    cyc(1'b0, 8'h00, 1'b0);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
- Parametrised single-clock synchronous FIFO; successor to the fixed 8-bit FIFO behind the team's FIFO interface.
- Generalises data width and depth.
- Adds an occupancy count, programmable almost-full/almost-empty thresholds and overflow/underflow error reporting.
- Sits between a producer and a consumer in the same clock domain; remains drivable by the existing driver/monitor clocking-block style.

Parameters:
- DATA_W, 8: data word width in bits.
- DEPTH, 16: number of entries; power of two, ≥ 4.
- AF_THRESH, DEPTH-2: almost_full asserts when count ≥ AF_THRESH.
- AE_THRESH, 2: almost_empty asserts when count ≤ AE_THRESH.
- CNT_W, $clog2(DEPTH)+1: width of count; derived, not overridden.

Ports:
- clk  in  1  sole clock; all logic on posedge.
- rst  in  1  synchronous reset, active-low; sampled on posedge clk.
- wr_en  in  1  write request.
- data_in  in  DATA_W  write data.
- rd_en  in  1  read request.
- data_out  out  DATA_W  read data, registered.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count ≥ AF_THRESH.
- almost_empty  out  1  count ≤ AE_THRESH.
- count  out  CNT_W  current occupancy, 0..DEPTH.
- overflow  out  1  write attempted and rejected (see Optional Feature).
- underflow  out  1  read attempted and rejected (see Optional Feature).

Behaviour:
- Interface decision: one clock, clk; reset is synchronous and active-low, port rst.
- Reset: rst==0 at a posedge clears the following, regardless of wr_en/rd_en in that cycle:
  - wr_ptr = 0, rd_ptr = 0, count = 0
  - data_out = 0, overflow = 0, underflow = 0
  - Resulting flags: empty=1, full=0, almost_empty=1, almost_full=0
- Storage contents are not reset.
- Reset mid-operation discards all stored entries; the first write after reset lands at address 0.
- Accept rules, evaluated at a posedge with rst==1:
  - rd_acc = rd_en & ~empty
  - wr_acc = wr_en & (~full | rd_acc)
- Write: mem[wr_ptr] ← data_in; wr_ptr increments modulo DEPTH (natural wrap, index width $clog2(DEPTH)).
- Read: data_out ← mem[rd_ptr]; rd_ptr increments modulo DEPTH.
  - Read latency is 1 cycle: data is valid on data_out after the edge that accepted rd_en.
  - data_out holds its last value when no read is accepted.
- Count update: +1 on wr_acc only, −1 on rd_acc only, unchanged when both or neither.
- Full with simultaneous rd_en & wr_en: both accepted; count stays DEPTH; the oldest word is read out and the new word is written into the freed slot.
- Empty with simultaneous rd_en & wr_en: read rejected (no bypass), write accepted, count → 1, data_out unchanged.
- full, empty, almost_full and almost_empty are combinational decodes of the count register, so they change on the same edge as count.
- No combinational path exists from any input to any output.
- Pointers never advance on rejected requests.

Optional Feature:
- Macro: FIFO_ERR_FLAGS_EN.
- Defined:
  - overflow sets at the edge where wr_en & ~wr_acc.
  - underflow sets at the edge where rd_en & ~rd_acc.
  - Both are sticky until reset.
  - Rejected requests also fire an immediate assertion error in simulation.
- Undefined: overflow and underflow are tied to 0 and no assertion is compiled. Port list is identical in both builds.

Test Plan (DEPTH=16, DATA_W=8, AF_THRESH=14, AE_THRESH=2):
- Reset → after rst low for 2 cycles: count=0, empty=1, almost_empty=1, full=0, almost_full=0, data_out=0x00.
- Write 0x00..0x0F in 16 cycles → full=1 after the 16th edge, almost_full=1 from count=14; a 17th write of 0xAA is rejected, count stays 16, overflow=1 (macro defined).
- From full, read 16 words → data_out sequence 0x00..0x0F, each valid 1 cycle after its rd_en edge; empty=1 after the last read; a further read gives data_out holding 0x0F and underflow=1.
- Wrap: write 10, read 10, write 10, read 10 → read data matches write order across pointer wrap; count ends at 0.
- Simultaneous rd_en & wr_en at count=16 → count stays 16, data_out = oldest word; at count=0 → count=1, data_out unchanged.
- Reset asserted at count=7 with wr_en=1 → count=0, empty=1; the next write of 0x5C reads back as 0x5C.
